// File: rtl/hdlc_pkg.sv
// Shared definitions for the Hdlc host-side register interface.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package hdlc_pkg;

    // Hdlc register map
    localparam int TX_SC   = 0;
    localparam int TX_BUFF = 1;
    localparam int RX_SC   = 2;
    localparam int RX_BUFF = 3;
    localparam int RX_LEN  = 4;

    // Rx_SC bit positions
    localparam int RX_SC_READY = 0;  // read: frame waiting
    localparam int RX_SC_DROP  = 1;  // write: discard current frame
    localparam int RX_SC_FERR  = 2;  // read: FCS error
    localparam int RX_SC_ABORT = 3;  // read: abort sequence seen
    localparam int RX_SC_OVF   = 4;  // read: buffer overflow

    typedef enum logic [3:0] {
        IDLE,
        RD_SC,
        CAP_SC,
        RD_LEN,
        CAP_LEN,
        RD_BUF,
        CAP_BUF,
        OUT,
        DROP
    } rx_rd_state_t;

endpackage

// File: rtl/hdlc_rx_reader.sv
// Drains received frames from the Hdlc Rx buffer onto a valid/ready byte stream.
// Latency: 6 cycles after the Rx_Ready sample to the first byte; 1 byte per 3 cycles.
// Backpressure: m_ready low holds the current byte in OUT; no register read is issued until it is taken.
//
// Ports: Clk/Rst (async active-low); Rx_Ready + Address/ReadEnable/WriteEnable/DataIn/DataOut
// form the Hdlc register port; m_data/m_valid/m_ready/m_last is the byte stream;
// frame_err pulses on each dropped frame; busy is high whenever the FSM is not idle.
module hdlc_rx_reader
    import hdlc_pkg::*;
#(
    parameter int MAX_LEN = 126,
    parameter int ADDR_W  = 3
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Rx_Ready,
    output logic [ADDR_W-1:0] Address,
    output logic              ReadEnable,
    output logic              WriteEnable,
    output logic [7:0]        DataIn,
    input  logic [7:0]        DataOut,
    output logic [7:0]        m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              frame_err,
    output logic              busy
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    rx_rd_state_t state, state_nxt;
    logic [7:0]   cnt;
    logic [7:0]   len;

    // Status says "frame present" but Hdlc flagged it as bad.
    logic sc_bad;
    assign sc_bad = DataOut[RX_SC_FERR] | DataOut[RX_SC_ABORT] | DataOut[RX_SC_OVF];

    // Length straight off the register port, evaluated in the capture cycle.
    logic len_bad;
    assign len_bad = (DataOut == 8'd0) || (DataOut > MAX_LEN_B);

    assign busy = (state != IDLE);

    always_comb begin
        state_nxt   = state;
        Address     = '0;
        ReadEnable  = 1'b0;
        WriteEnable = 1'b0;
        DataIn      = 8'h00;
        m_valid     = 1'b0;
        m_last      = 1'b0;
        frame_err   = 1'b0;
        case (state)
            IDLE: begin
                if (Rx_Ready) state_nxt = RD_SC;
            end
            RD_SC: begin
                Address    = ADDR_W'(RX_SC);
                ReadEnable = 1'b1;
                state_nxt  = CAP_SC;
            end
            CAP_SC: begin
                if (!DataOut[RX_SC_READY]) state_nxt = IDLE;   // spurious wake
                else if (sc_bad)           state_nxt = DROP;
                else                       state_nxt = RD_LEN;
            end
            RD_LEN: begin
                Address    = ADDR_W'(RX_LEN);
                ReadEnable = 1'b1;
                state_nxt  = CAP_LEN;
            end
            CAP_LEN: begin
                state_nxt = len_bad ? DROP : RD_BUF;
            end
            RD_BUF: begin
                Address    = ADDR_W'(RX_BUFF);
                ReadEnable = 1'b1;
                state_nxt  = CAP_BUF;
            end
            CAP_BUF: begin
                state_nxt = OUT;
            end
            OUT: begin
                m_valid = 1'b1;
                m_last  = (cnt == 8'd1);
                // cnt <= 1 means this is the final byte once accepted
                if (m_ready) state_nxt = (cnt <= 8'd1) ? IDLE : RD_BUF;
            end
            DROP: begin
                Address     = ADDR_W'(RX_SC);
                WriteEnable = 1'b1;
                DataIn      = 8'(1 << RX_SC_DROP);
                frame_err   = 1'b1;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state  <= IDLE;
            cnt    <= 8'd0;
            len    <= 8'd0;
            m_data <= 8'd0;
        end else begin
            state <= state_nxt;
            if (state == CAP_LEN) begin
                len <= DataOut;
                if (!len_bad) cnt <= DataOut;
            end
            if (state == CAP_BUF) m_data <= DataOut;
            // Guarded decrement: cnt can never wrap below zero.
            if (state == OUT && m_ready && cnt != 8'd0) cnt <= cnt - 8'd1;
        end
    end

    // Remaining count must stay within the frame length latched for it.
    always_ff @(posedge Clk) begin
        if (Rst && state == OUT) assert (cnt != 8'd0 && cnt <= len);
    end

endmodule
